// File: rtl/watch_time_serializer.sv
// Snapshots the ripple-clocked watch time registers, decodes them to binary and
// sends one UART-style frame per request. Define WATCH_TX_PARITY_EN to append an even-parity bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle high, waiting for a synchronized req rising edge
// S_SETTLE | waiting for STABLE_SAMPLES identical samples or the timeout
// S_LATCH  | decode into output registers, pulse snap_valid, load frame
// S_START  | start bit (low)
// S_DATA   | 17 payload bits, LSB first
// S_PARITY | even parity over the payload (optional)
// S_STOP   | stop bit (high), then back to idle
module watch_time_serializer #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int STABLE_SAMPLES = 2,
  parameter int STABLE_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  sec_fine_i,
  input  logic [11:0] sec_coarse_i,
  input  logic [3:0]  min_fine_i,
  input  logic [11:0] min_coarse_i,
  input  logic [11:0] hours_i,
  input  logic        req_i,
  output logic        busy_o,
  output logic        tx_o,
  output logic [5:0]  secs_bin_o,
  output logic [5:0]  mins_bin_o,
  output logic [3:0]  hours_bin_o,
  output logic        enc_err_o,
  output logic        snap_valid_o
);

  localparam int                TMO_W     = $clog2(STABLE_TIMEOUT + 1);
  localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        MATCH_TGT = 4'(STABLE_SAMPLES);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(STABLE_TIMEOUT);

`ifdef WATCH_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LATCH, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LATCH, S_START, S_DATA, S_STOP} state_t;
`endif

  // Returns {bad, value[2:0]} for a thermometer code.
  function automatic logic [3:0] fine_dec(input logic [3:0] code);
    case (code)
      4'b0000: fine_dec = 4'b0_000;
      4'b1000: fine_dec = 4'b0_001;
      4'b1100: fine_dec = 4'b0_010;
      4'b1110: fine_dec = 4'b0_011;
      4'b1111: fine_dec = 4'b0_100;
      default: fine_dec = 4'b1_000;
    endcase
  endfunction

  // Returns {bad, index[3:0]}; bit k maps to index 11-k.
  function automatic logic [4:0] onehot_dec(input logic [11:0] code);
    logic [3:0] cnt;
    logic [3:0] idx;
    cnt = '0;
    idx = '0;
    for (int k = 0; k < 12; k++) begin
      if (code[k]) begin
        cnt = cnt + 4'd1;
        idx = 4'(11 - k);
      end
    end
    onehot_dec = (cnt == 4'd1) ? {1'b0, idx} : 5'b1_0000;
  endfunction

  logic [43:0] bus_raw, bus_s1_q, bus_s2_q, bus_prev_q;
  logic        req_s1_q, req_s2_q, req_prev_q;

  assign bus_raw = {hours_i, min_coarse_i, min_fine_i, sec_coarse_i, sec_fine_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_s1_q   <= '0;
      bus_s2_q   <= '0;
      bus_prev_q <= '0;
      req_s1_q   <= 1'b0;
      req_s2_q   <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      bus_s1_q   <= bus_raw;
      bus_s2_q   <= bus_s1_q;
      bus_prev_q <= bus_s2_q;
      req_s1_q   <= req_i;
      req_s2_q   <= req_s1_q;
      req_prev_q <= req_s2_q;
    end
  end

  logic [3:0] sf, mf;
  logic [4:0] sc, mc, hc;
  logic [5:0] secs_dec, mins_dec;
  logic       dec_bad;

  always_comb begin
    sf       = fine_dec(bus_s2_q[3:0]);
    sc       = onehot_dec(bus_s2_q[15:4]);
    mf       = fine_dec(bus_s2_q[19:16]);
    mc       = onehot_dec(bus_s2_q[31:20]);
    hc       = onehot_dec(bus_s2_q[43:32]);
    secs_dec = {2'b00, sc[3:0]} * 6'd5 + {3'b000, sf[2:0]};
    mins_dec = {2'b00, mc[3:0]} * 6'd5 + {3'b000, mf[2:0]};
    dec_bad  = sf[3] | sc[4] | mf[3] | mc[4] | hc[4];
  end

  state_t            state_q, state_d;
  logic [3:0]        match_q, match_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tflag_q, tflag_d;
  logic [15:0]       baud_q, baud_d;
  logic [4:0]        bit_q, bit_d;
  logic [16:0]       shift_q, shift_d;
  logic [5:0]        secs_q, secs_d, mins_q, mins_d;
  logic [3:0]        hours_q, hours_d;
  logic              err_q, err_d, snap_q, snap_d;
`ifdef WATCH_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    tflag_d = tflag_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    secs_d  = secs_q;
    mins_d  = mins_q;
    hours_d = hours_q;
    err_d   = err_q;
    snap_d  = 1'b0;
`ifdef WATCH_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_s2_q && !req_prev_q) begin
          state_d = S_SETTLE;
          match_d = '0;
          tmo_d   = TMO_LOAD;
          tflag_d = 1'b0;
        end
      end
      S_SETTLE: begin
        match_d = (bus_s2_q == bus_prev_q) ? match_q + 4'd1 : 4'd0;
        tmo_d   = tmo_q - TMO_W'(1);
        if (match_d == MATCH_TGT) begin
          state_d = S_LATCH;
        end else if (tmo_q == TMO_W'(1)) begin
          state_d = S_LATCH;
          tflag_d = 1'b1;
        end
      end
      S_LATCH: begin
        secs_d  = secs_dec;
        mins_d  = mins_dec;
        hours_d = hc[3:0];
        err_d   = dec_bad | tflag_q;
        snap_d  = 1'b1;
        shift_d = {err_d, hc[3:0], mins_dec, secs_dec};
`ifdef WATCH_TX_PARITY_EN
        par_d   = ^shift_d;
`endif
        baud_d  = BAUD_LAST;
        state_d = S_START;
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_LAST;
          shift_d = shift_q >> 1;
          if (bit_q == 5'd16) begin
            bit_d = '0;
`ifdef WATCH_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef WATCH_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_LAST;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      match_q <= '0;
      tmo_q   <= '0;
      tflag_q <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      secs_q  <= '0;
      mins_q  <= '0;
      hours_q <= '0;
      err_q   <= 1'b0;
      snap_q  <= 1'b0;
`ifdef WATCH_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
      tflag_q <= tflag_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      secs_q  <= secs_d;
      mins_q  <= mins_d;
      hours_q <= hours_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
`ifdef WATCH_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx decodes straight from state so an async reset forces the line high at once.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shift_q[0];
`ifdef WATCH_TX_PARITY_EN
      S_PARITY: tx_o = par_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign secs_bin_o   = secs_q;
  assign mins_bin_o   = mins_q;
  assign hours_bin_o  = hours_q;
  assign enc_err_o    = err_q;
  assign snap_valid_o = snap_q;

endmodule
